prog_mem: RTL

PROG_MEM -- requirements
Module: prog_mem

---
 rtl/prog_mem_pkg.sv | 55 +++++
 rtl/prog_mem_array.sv | 47 ++++
 rtl/prog_mem.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_pkg.sv
// -----------------------------------------------------------------------------
// prog_mem_pkg
// Shared definitions for the program memory slice: instruction opcode and
// register encodings, the default instruction returned for out-of-range
// fetches, and the FSM / output-source encodings used by prog_mem.
// -----------------------------------------------------------------------------
package prog_mem_pkg;

    // 4-bit opcode field occupying the top of a 28-bit instruction word.
    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_JMP   = 4'h8,
        OP_BEQ   = 4'h9,
        OP_LED   = 4'hA,
        OP_HALT  = 4'hF
    } opcode_e;

    // General-purpose register file encodings.
    typedef enum logic [2:0] {
        REG_R0 = 3'd0,
        REG_R1 = 3'd1,
        REG_R2 = 3'd2,
        REG_R3 = 3'd3,
        REG_R4 = 3'd4,
        REG_R5 = 3'd5,
        REG_R6 = 3'd6,
        REG_R7 = 3'd7
    } reg_e;

    localparam int unsigned INSTR_WIDTH = 28;

    // Returned for fetches beyond the populated depth: LED with a fixed pattern.
    localparam logic [INSTR_WIDTH-1:0] PROG_MEM_DEFAULT_INSTR = {OP_LED, 24'b10101010};

    // Controller states.
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } pm_state_e;

    // Which value drives oInstruction.
    typedef enum logic [1:0] {
        SRC_ZERO    = 2'd0,
        SRC_MEM     = 2'd1,
        SRC_DEFAULT = 2'd2
    } pm_src_e;

endpackage : prog_mem_pkg

// File: rtl/prog_mem_array.sv
// -----------------------------------------------------------------------------
// prog_mem_array
// DEPTH x WIDTH storage with one synchronous write port and one registered
// read port. Contents are not reset. The read register only updates when
// re is high, so it holds its value otherwise.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   re     in   read enable (loads the read register)
//   raddr  in   read index
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module prog_mem_array #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule : prog_mem_array

// File: rtl/prog_mem.sv
// -----------------------------------------------------------------------------
// prog_mem
// Loadable program memory with a two-state controller (LOAD / RUN).
// LOAD accepts writes from a loader, RUN serves single-cycle-latency
// instruction fetches with stall hold.
//
// Optional feature: define PROG_MEM_PARITY_EN to store an even-parity bit per
// word, check it on every fetch and expose oParityError.
//
// Ports:
//   Clock         in   clock, rising edge
//   Reset         in   asynchronous active-low reset
//   iLoadStart    in   RUN -> LOAD request
//   iLoadWrite    in   write strobe (LOAD only)
//   iLoadAddress  in   write address
//   iLoadData     in   write data
//   iLoadDone     in   LOAD -> RUN request
//   iReadRequest  in   fetch request (RUN only)
//   iAddress      in   fetch address
//   iStall        in   hold current fetch output
//   oInstruction  out  fetched word
//   oValid        out  oInstruction is a valid fetch result
//   oLoading      out  high in LOAD
//   oLoadCount    out  accepted writes since entering LOAD (saturates at DEPTH)
//   oLoadError    out  one-cycle pulse on an out-of-range write
//   oParityError  out  (PROG_MEM_PARITY_EN only) parity check failed on fetch
// -----------------------------------------------------------------------------
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 28,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iLoadStart,
    input  logic                  iLoadWrite,
    input  logic [ADDR_WIDTH-1:0] iLoadAddress,
    input  logic [DATA_WIDTH-1:0] iLoadData,
    input  logic                  iLoadDone,
    input  logic                  iReadRequest,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    input  logic                  iStall,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oValid,
    output logic                  oLoading,
    output logic [ADDR_WIDTH:0]   oLoadCount,
`ifdef PROG_MEM_PARITY_EN
    output logic                  oParityError,
`endif
    output logic                  oLoadError
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PROG_MEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_WIDTH + 1;
`else
    localparam int unsigned MEM_W = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH:0]   DEPTH_W      = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(PROG_MEM_DEFAULT_INSTR);

    pm_state_e             state_q, state_d;
    pm_src_e               src_q,   src_d;
    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  err_q,   err_d;

    logic                  mem_we;
    logic                  mem_re;
    logic [MEM_W-1:0]      mem_wdata;
    logic [MEM_W-1:0]      mem_rdata;
    logic                  load_in_range;
    logic                  fetch_in_range;

    assign load_in_range  = {1'b0, iLoadAddress} < DEPTH_W;
    assign fetch_in_range = {1'b0, iAddress} < DEPTH_W;

`ifdef PROG_MEM_PARITY_EN
    assign mem_wdata = {^iLoadData, iLoadData};
`else
    assign mem_wdata = iLoadData;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        valid_d = valid_q;
        count_d = count_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                valid_d = 1'b0;
                if (iLoadWrite) begin
                    if (load_in_range) begin
                        // Array strobes are gated by Reset so nothing commits
                        // while reset is held across a clock edge.
                        mem_we = Reset;
                        if (count_q != DEPTH_W) begin
                            count_d = count_q + COUNT_ONE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (iLoadDone) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (iLoadStart) begin
                    state_d = ST_LOAD;
                    valid_d = 1'b0;
                    count_d = '0;
                    src_d   = SRC_ZERO;
                end else if (!iStall) begin
                    if (iReadRequest) begin
                        valid_d = 1'b1;
                        if (fetch_in_range) begin
                            src_d  = SRC_MEM;
                            mem_re = Reset;
                        end else begin
                            src_d  = SRC_DEFAULT;
                        end
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_LOAD;
            src_q   <= SRC_ZERO;
            valid_q <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    prog_mem_array #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (Clock),
        .we    (mem_we),
        .waddr (iLoadAddress[IDX_W-1:0]),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (iAddress[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

    // The array read register has no reset; src_q (which is reset) selects
    // what reaches oInstruction so reset forces zero immediately.
    always_comb begin
        unique case (src_q)
            SRC_ZERO:    oInstruction = '0;
            SRC_MEM:     oInstruction = mem_rdata[DATA_WIDTH-1:0];
            SRC_DEFAULT: oInstruction = DEFAULT_WORD;
            default:     oInstruction = '0;
        endcase
    end

`ifdef PROG_MEM_PARITY_EN
    // Stored word plus parity bit must have an even number of ones.
    assign oParityError = valid_q && (src_q == SRC_MEM) && (^mem_rdata);
`endif

    assign oValid     = valid_q;
    assign oLoading   = (state_q == ST_LOAD);
    assign oLoadCount = count_q;
    assign oLoadError = err_q;

endmodule : prog_mem
